// File: rtl/fft_ifft_dual.sv
// Forward/inverse transform around one shared fft core. Each frame carries a direction
// tag through a small FIFO so FFT and IFFT frames can run back-to-back.

module fft #(
  parameter int TOTAL_STAGE_P = 10,
  parameter int MULT_OP_DLY_P = 2,
  parameter int MULT_WIDTH_P  = 18
) (
  input  logic                            iclk,
  input  logic                            rst_n,
  input  logic                            ien,
  input  logic        [TOTAL_STAGE_P-1:0] iaddr,
  input  logic signed [MULT_WIDTH_P-1:0]  iReal,
  input  logic signed [MULT_WIDTH_P-1:0]  iImag,
  output logic                            oen,
  output logic        [TOTAL_STAGE_P-1:0] oaddr,
  output logic signed [MULT_WIDTH_P-1:0]  oReal,
  output logic signed [MULT_WIDTH_P-1:0]  oImag
);
  // Latency model of the core: samples travel STAGES register stages unchanged.
  localparam int STAGES = TOTAL_STAGE_P + 2*MULT_OP_DLY_P;

  typedef struct packed {
    logic        [TOTAL_STAGE_P-1:0] addr;
    logic signed [MULT_WIDTH_P-1:0]  re;
    logic signed [MULT_WIDTH_P-1:0]  im;
  } smp_t;

  logic [STAGES-1:0] vld_pipe;
  smp_t              dat_pipe [STAGES];

  always_ff @(posedge iclk) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-2:0], ien};
  end

  always_ff @(posedge iclk) begin
    dat_pipe[0] <= '{addr: iaddr, re: iReal, im: iImag};
    for (int i = 1; i < STAGES; i++) dat_pipe[i] <= dat_pipe[i-1];
  end

  assign oen   = vld_pipe[STAGES-1];
  assign oaddr = dat_pipe[STAGES-1].addr;
  assign oReal = dat_pipe[STAGES-1].re;
  assign oImag = dat_pipe[STAGES-1].im;
endmodule

module fft_ifft_dual #(
  parameter int TOTAL_STAGE_P = 10,
  parameter int DIV_EXP       = TOTAL_STAGE_P,
  parameter int MULT_OP_DLY_P = 2,
  parameter int MULT_WIDTH_P  = 18,
  parameter int TAG_DEPTH_P   = 4
) (
  input  logic                            iclk,
  input  logic                            rst_n,
  input  logic                            ien,
  input  logic                            iinv,
  input  logic        [TOTAL_STAGE_P-1:0] iaddr,
  input  logic signed [MULT_WIDTH_P-1:0]  iReal,
  input  logic signed [MULT_WIDTH_P-1:0]  iImag,
  output logic                            oen,
  output logic                            oinv,
  output logic        [TOTAL_STAGE_P-1:0] oaddr,
  output logic signed [MULT_WIDTH_P-1:0]  oReal,
  output logic signed [MULT_WIDTH_P-1:0]  oImag,
  output logic                            osat,
  output logic                            oerr
);
  localparam int W   = MULT_WIDTH_P;
  localparam int TAW = $clog2(TAG_DEPTH_P);
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] SMAX = ~SMIN;
  localparam logic signed [W:0]   RND  = (W+1)'(1 << (DIV_EXP-1));

  function automatic logic signed [W-1:0] rnd(input logic signed [W-1:0] x);
    logic signed [W:0] t;
    t = (W+1)'(x) + RND;
    t = t >>> DIV_EXP;
    return t[W-1:0];
  endfunction

  // Input side: the frame-start beat uses iinv directly, the rest of the frame the latched mode.
  logic               mode_in_q, fs_in, mode_eff_in;
  logic signed [W-1:0] c_in_im;

  assign fs_in       = ien && (iaddr == '0);
  assign mode_eff_in = fs_in ? iinv : mode_in_q;
  assign c_in_im     = mode_eff_in ? -iImag : iImag;

  logic                     c_en;
  logic [TOTAL_STAGE_P-1:0] c_addr;
  logic signed [W-1:0]      c_re, c_im;

  fft #(
    .TOTAL_STAGE_P(TOTAL_STAGE_P),
    .MULT_OP_DLY_P(MULT_OP_DLY_P),
    .MULT_WIDTH_P (MULT_WIDTH_P)
  ) u_core (
    .iclk (iclk),
    .rst_n(rst_n),
    .ien  (ien),
    .iaddr(iaddr),
    .iReal(iReal),
    .iImag(c_in_im),
    .oen  (c_en),
    .oaddr(c_addr),
    .oReal(c_re),
    .oImag(c_im)
  );

  // Direction tag FIFO
  logic [TAG_DEPTH_P-1:0] tag_q;
  logic [TAW:0]           wr_q, rd_q, wr_d, rd_d;
  logic                   push, pop, empty, full, wr_en, pop_val, err_d, oerr_q;

  always_comb begin
    push    = fs_in;
    pop     = c_en && (c_addr == '0);
    empty   = (wr_q == rd_q);
    full    = (wr_q[TAW] != rd_q[TAW]) && (wr_q[TAW-1:0] == rd_q[TAW-1:0]);
    wr_d    = wr_q;
    rd_d    = rd_q;
    wr_en   = 1'b0;
    pop_val = 1'b0;
    err_d   = oerr_q;
    if (pop) begin
      if (!empty) begin
        pop_val = tag_q[rd_q[TAW-1:0]];
        rd_d    = rd_q + (TAW+1)'(1);
      end else if (push) begin
        pop_val = iinv;
      end else begin
        err_d = 1'b1;
      end
    end
    // An empty-FIFO push consumed by a same-cycle pop bypasses storage entirely.
    if (push && !(empty && pop)) begin
      if (!full || pop) begin
        wr_en = 1'b1;
        wr_d  = wr_q + (TAW+1)'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Output side conditioning
  logic                mode_out_q, mode_eff_out, sat;
  logic signed [W-1:0] neg_im, out_re, out_im;

  assign mode_eff_out = pop ? pop_val : mode_out_q;
  assign sat          = (c_im == SMIN);
  assign neg_im       = sat ? SMAX : -c_im;
  assign out_re       = mode_eff_out ? rnd(c_re)   : c_re;
  assign out_im       = mode_eff_out ? rnd(neg_im) : c_im;

  logic                     oen_q, oinv_q, osat_q;
  logic [TOTAL_STAGE_P-1:0] oaddr_q;
  logic signed [W-1:0]      ore_q, oim_q;

  always_ff @(posedge iclk) begin
    if (!rst_n) begin
      tag_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      mode_in_q  <= 1'b0;
      mode_out_q <= 1'b0;
      oerr_q     <= 1'b0;
      oen_q      <= 1'b0;
      oinv_q     <= 1'b0;
      oaddr_q    <= '0;
      ore_q      <= '0;
      oim_q      <= '0;
      osat_q     <= 1'b0;
    end else begin
      if (wr_en) tag_q[wr_q[TAW-1:0]] <= iinv;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      oerr_q     <= err_d;
      mode_in_q  <= mode_eff_in;
      mode_out_q <= mode_eff_out;
      oen_q      <= c_en;
      osat_q     <= c_en && mode_eff_out && sat;
      if (c_en) begin
        oinv_q  <= mode_eff_out;
        oaddr_q <= c_addr;
        ore_q   <= out_re;
        oim_q   <= out_im;
      end
    end
  end

  assign oen   = oen_q;
  assign oinv  = oinv_q;
  assign oaddr = oaddr_q;
  assign oReal = ore_q;
  assign oImag = oim_q;
  assign osat  = osat_q;
  assign oerr  = oerr_q;
endmodule

// File: tb/tb_fft_ifft_dual.sv
// Directed bench for fft_ifft_dual: small N, hand-computed rounding/saturation results.

module tb_fft_ifft_dual;
  localparam int TS  = 3;
  localparam int N   = 8;
  localparam int W   = 18;
  localparam int DE  = 3;
  localparam int MD  = 2;
  localparam int TD  = 4;
  localparam int LAT = TS + 2*MD + 1;

  logic                 iclk = 1'b0, rst_n = 1'b0, ien = 1'b0, iinv = 1'b0;
  logic        [TS-1:0] iaddr = '0;
  logic signed [W-1:0]  iReal = '0, iImag = '0;
  logic                 oen, oinv, osat, oerr;
  logic        [TS-1:0] oaddr;
  logic signed [W-1:0]  oReal, oImag;

  fft_ifft_dual #(
    .TOTAL_STAGE_P(TS), .DIV_EXP(DE), .MULT_OP_DLY_P(MD), .MULT_WIDTH_P(W), .TAG_DEPTH_P(TD)
  ) dut (
    .iclk(iclk), .rst_n(rst_n), .ien(ien), .iinv(iinv), .iaddr(iaddr),
    .iReal(iReal), .iImag(iImag), .oen(oen), .oinv(oinv), .oaddr(oaddr),
    .oReal(oReal), .oImag(oImag), .osat(osat), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc++;

  typedef struct {int c; logic inv; int addr; int re; int im; logic sat;} beat_t;
  beat_t cap[$];
  always @(negedge iclk)
    if (oen === 1'b1) cap.push_back('{cyc, oinv, int'(oaddr), int'(oReal), int'(oImag), osat});

  int checks = 0, errors = 0;
  int fre[N], fim[N];
  int start_cyc;

  task automatic drive(input logic en, input logic inv, input int a, input int re, input int im);
    @(posedge iclk); #1;
    ien = en; iinv = inv; iaddr = a[TS-1:0]; iReal = re[W-1:0]; iImag = im[W-1:0];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic send(input logic inv, input int tog);
    for (int i = 0; i < N; i++) begin
      drive(1'b1, (tog >= 0 && i >= tog) ? ~inv : inv, i, fre[i], fim[i]);
      if (i == 0) start_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    @(negedge iclk);
    checks++;
    if ({oen, oinv, oaddr, oReal, oImag, osat, oerr} !== '0) begin
      errors++;
      $display("FAIL reset: got oen=%b oinv=%b oaddr=%0d re=%0d im=%0d osat=%b oerr=%b, want all 0",
               oen, oinv, oaddr, oReal, oImag, osat, oerr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fft_impulse();
    int ere[N] = '{1000, 0, 0, 0, 0, 0, 0, 0};
    beat_t b;
    fre = ere; fim = '{default: 0};
    cap.delete();
    send(1'b0, -1);
    idle(LAT + 2);
    checks++;
    if (cap.size() != N) begin
      errors++; $display("FAIL fft_impulse count: got %0d beats, want %0d", cap.size(), N);
    end
    if (cap.size() > 0) begin
      checks++;
      if (cap[0].c - start_cyc != LAT) begin
        errors++; $display("FAIL fft_impulse latency: got %0d, want %0d", cap[0].c - start_cyc, LAT);
      end
    end
    for (int i = 0; i < N && cap.size() > 0; i++) begin
      b = cap.pop_front();
      checks++;
      if (b.addr != i || b.inv !== 1'b0 || b.re != ere[i] || b.im != 0 || b.sat !== 1'b0) begin
        errors++;
        $display("FAIL fft_impulse beat %0d: got addr=%0d inv=%b re=%0d im=%0d sat=%b, want re=%0d im=0",
                 i, b.addr, b.inv, b.re, b.im, b.sat, ere[i]);
      end
    end
    checks++;
    if (oerr !== 1'b0) begin errors++; $display("FAIL fft_impulse oerr: got %b, want 0", oerr); end
  endtask

  task automatic test_ifft_round();
    int ere[N] = '{128, 1, 0, 0, -1, 2, -1, 1};
    int eim[N] = '{0, 0, 1, 0, 0, 13, -12, 3};
    beat_t b;
    fre = '{1024, 4, 3, -4, -5, 12, -12, 7};
    fim = '{0, 1, 5, -3, -4, 100, -100, 20};
    cap.delete();
    send(1'b1, -1);
    idle(LAT + 2);
    checks++;
    if (cap.size() != N) begin
      errors++; $display("FAIL ifft_round count: got %0d beats, want %0d", cap.size(), N);
    end
    for (int i = 0; i < N && cap.size() > 0; i++) begin
      b = cap.pop_front();
      checks++;
      if (b.addr != i || b.inv !== 1'b1 || b.re != ere[i] || b.im != eim[i] || b.sat !== 1'b0) begin
        errors++;
        $display("FAIL ifft_round beat %0d: got addr=%0d inv=%b re=%0d im=%0d sat=%b, want re=%0d im=%0d inv=1",
                 i, b.addr, b.inv, b.re, b.im, b.sat, ere[i], eim[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic finv[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int   fin[4]  = '{80, 88, 96, 104};
    int   ere[4]  = '{80, 11, 12, 104};
    int   eim[4]  = '{-80, -11, -12, -104};
    beat_t b;
    cap.delete();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < N; i++) drive(1'b1, finv[f], i, fin[f], -fin[f]);
    idle(LAT + 2);
    checks++;
    if (cap.size() != 4*N) begin
      errors++; $display("FAIL back_to_back count: got %0d beats, want %0d", cap.size(), 4*N);
    end
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < N && cap.size() > 0; i++) begin
        b = cap.pop_front();
        checks++;
        if (b.addr != i || b.inv !== finv[f] || b.re != ere[f] || b.im != eim[f] || b.sat !== 1'b0) begin
          errors++;
          $display("FAIL back_to_back f%0d beat %0d: got addr=%0d inv=%b re=%0d im=%0d, want inv=%b re=%0d im=%0d",
                   f, i, b.addr, b.inv, b.re, b.im, finv[f], ere[f], eim[f]);
        end
      end
    checks++;
    if (oerr !== 1'b0) begin errors++; $display("FAIL back_to_back oerr: got %b, want 0", oerr); end
  endtask

  task automatic test_mid_toggle();
    beat_t b;
    for (int i = 0; i < N; i++) begin fre[i] = 50 + i; fim[i] = -i; end
    cap.delete();
    send(1'b0, 4);
    idle(LAT + 2);
    checks++;
    if (cap.size() != N) begin
      errors++; $display("FAIL mid_toggle count: got %0d beats, want %0d", cap.size(), N);
    end
    for (int i = 0; i < N && cap.size() > 0; i++) begin
      b = cap.pop_front();
      checks++;
      if (b.addr != i || b.inv !== 1'b0 || b.re != 50 + i || b.im != -i || b.sat !== 1'b0) begin
        errors++;
        $display("FAIL mid_toggle beat %0d: got inv=%b re=%0d im=%0d, want inv=0 re=%0d im=%0d",
                 i, b.inv, b.re, b.im, 50 + i, -i);
      end
    end
  endtask

  task automatic test_saturation();
    int ere[N] = '{0, 0, -16384, 0, 0, 16384, 0, 0};
    int eim[N] = '{1, 1, 16384, 1, 1, 1, 1, 1};
    beat_t b;
    fre = '{0, 0, -131072, 0, 0, 131071, 0, 0};
    fim = '{8, 8, -131072, 8, 8, 8, 8, 8};
    cap.delete();
    send(1'b1, -1);
    idle(LAT + 2);
    checks++;
    if (cap.size() != N) begin
      errors++; $display("FAIL saturation count: got %0d beats, want %0d", cap.size(), N);
    end
    for (int i = 0; i < N && cap.size() > 0; i++) begin
      b = cap.pop_front();
      checks++;
      if (b.addr != i || b.inv !== 1'b1 || b.re != ere[i] || b.im != eim[i] || b.sat !== (i == 2)) begin
        errors++;
        $display("FAIL saturation beat %0d: got re=%0d im=%0d sat=%b, want re=%0d im=%0d sat=%b",
                 i, b.re, b.im, b.sat, ere[i], eim[i], i == 2);
      end
    end
    @(negedge iclk);
    checks++;
    if (oen !== 1'b0 || osat !== 1'b0 || oImag != 16'sd1) begin
      errors++; $display("FAIL saturation idle: got oen=%b osat=%b im=%0d, want oen=0 osat=0 im=1 held", oen, osat, oImag);
    end
  endtask

  task automatic test_fifo_err();
    cap.delete();
    repeat (TD + 1) drive(1'b1, 1'b1, 0, 0, 0);
    idle(LAT + 3);
    checks++;
    if (oerr !== 1'b1) begin errors++; $display("FAIL fifo_overflow oerr: got %b, want 1", oerr); end
    cap.delete();
  endtask

  task automatic test_reset_midframe();
    int ere[N] = '{7, -7, 0, 100, -100, 131071, -131072, 1};
    beat_t b;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i, 5, 5);
    @(posedge iclk); #1;
    rst_n = 1'b0; ien = 1'b0;
    cap.delete();
    @(posedge iclk);
    @(negedge iclk);
    checks++;
    if ({oen, oinv, oaddr, oReal, oImag, osat, oerr} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got oen=%b oinv=%b oaddr=%0d re=%0d im=%0d osat=%b oerr=%b, want all 0",
               oen, oinv, oaddr, oReal, oImag, osat, oerr);
    end
    rst_n = 1'b1;
    idle(LAT + 4);
    checks++;
    if (cap.size() != 0) begin
      errors++; $display("FAIL midframe_flush: got %0d stale beats, want 0", cap.size());
    end
    fre = ere; fim = '{1, 2, 3, 4, 5, 6, 7, 8};
    cap.delete();
    send(1'b0, -1);
    idle(LAT + 2);
    checks++;
    if (cap.size() != N) begin
      errors++; $display("FAIL post_reset count: got %0d beats, want %0d", cap.size(), N);
    end
    for (int i = 0; i < N && cap.size() > 0; i++) begin
      b = cap.pop_front();
      checks++;
      if (b.addr != i || b.inv !== 1'b0 || b.re != ere[i] || b.im != i + 1 || b.sat !== 1'b0) begin
        errors++;
        $display("FAIL post_reset beat %0d: got inv=%b re=%0d im=%0d, want inv=0 re=%0d im=%0d",
                 i, b.inv, b.re, b.im, ere[i], i + 1);
      end
    end
    checks++;
    if (oerr !== 1'b0) begin errors++; $display("FAIL post_reset oerr: got %b, want 0", oerr); end
  endtask

  initial begin
    test_reset();
    test_fft_impulse();
    test_ifft_round();
    test_back_to_back();
    test_mid_toggle();
    test_saturation();
    test_fifo_err();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_ifft_dual.md
# fft_ifft_dual

Runtime-selectable forward/inverse transform block built around the existing `fft` core. Direction is chosen per frame, and each frame's direction tag is carried through the core's pipeline by a small tag FIFO. The FIFO lets FFT and IFFT frames be interleaved back-to-back. In inverse mode the block applies input conjugation, output conjugation, a rounded divide by 2^DIV_EXP, and saturation on negation overflow. It replaces the fixed-direction IFFT wrapper wherever both directions share one core.

## Interface
- TOTAL_STAGE_P, 10: log2 of the transform size N; legal range 3..11.
- DIV_EXP, TOTAL_STAGE_P: right-shift applied to inverse-mode outputs; legal range 1..MULT_WIDTH_P-1.
- MULT_OP_DLY_P, 2: multiplier latency passed to the core; 2 or 6.
- MULT_WIDTH_P, 18: width of each real and imaginary component, two's complement; 9 or 18.
- TAG_DEPTH_P, 4: number of frames that may be in flight; a power of 2 and at least 2.
- iclk  in  1  clock; all logic is clocked on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ien  in  1  input sample valid.
- iinv  in  1  direction: 1 = IFFT, 0 = FFT; sampled only on a frame-start beat.
- iaddr  in  TOTAL_STAGE_P  sample index; iaddr==0 with ien marks the frame start.
- iReal, iImag  in  MULT_WIDTH_P each  input sample.
- oen  out  1  output valid.
- oinv  out  1  direction tag of the current output frame.
- oaddr  out  TOTAL_STAGE_P  output index.
- oReal, oImag  out  MULT_WIDTH_P each  output sample.
- osat  out  1  this beat saturated during conjugation.
- oerr  out  1  sticky tag FIFO overflow or underflow; cleared only by reset.

## Operation
- **Frame start (ien && iaddr==0):**
  - Register mode_in <= iinv.
  - Push iinv into the tag FIFO.
  - The direction used on this beat is iinv itself.
- **Other ien beats:** use mode_in. A change of iinv mid-frame has no effect until the next frame start.
- **Input conditioning:**
  - When the effective mode is 1, negate the imaginary part before the core.
  - When the effective mode is 0, pass the sample through unchanged.
  - This path is combinational into the core, exactly as in the fixed-direction wrapper.
- **Core:** one `fft` instance with TOTAL_STAGE_P, MULT_OP_DLY_P and MULT_WIDTH_P passed through. Core latency is L_core.
- **Output frame start (core oen && core addr==0):**
  - Pop the FIFO into mode_out.
  - The popped value is used on this same beat.
- **Other core oen beats:** use mode_out.
- **Output, mode 1:**
  - Imaginary part: imag' = -imag. If imag == -2^(W-1), imag' = 2^(W-1)-1 and osat=1 for that beat.
  - Both components: y = (x + 2^(DIV_EXP-1)) >>> DIV_EXP, computed in W+1 bits with an arithmetic shift, then truncated to W bits. This cannot overflow.
- **Output, mode 0:** pass through unchanged; osat=0.
- **Tag FIFO:**
  - TAG_DEPTH_P entries, read and write pointers each one bit wider than the address.
  - Full: push is dropped and oerr is set. Exception: when a push and a pop occur on the same cycle while full, the pop is taken first and the push succeeds, with no error.
  - Empty: a pop sets oerr, mode 0 is used, and the pointers do not move. A push and pop on the same cycle while empty takes the pushed value, with no error.
- **Reset (rst_n==0 at a clock edge):**
  - Outputs: oen, oinv, oaddr, oReal, oImag, osat and oerr all go to 0.
  - Internal state: the FIFO is emptied and mode_in and mode_out are cleared.
  - The core is reset through the same rst_n.
  - Any frame in flight when reset is asserted is discarded, and its remaining output beats never appear.

## Timing
- Total latency from an ien beat to its oen beat is L_core + 1. The final output register adds the 1.
- Throughput: one sample per clock, with no stalls.
- Frames may be back-to-back: the frame-start beat of frame k+1 may immediately follow the last beat of frame k, with a different iinv.
- oinv, oaddr, oReal, oImag and osat are all registered on the same edge as oen, so they stay aligned.
- When oen=0, the data outputs hold their previous values. osat is 0.
- The FIFO push occurs on the frame-start edge. The pop is combinational-read, and the pointer advances on that edge.

## Test plan
- **Forward, impulse:** iinv=0, impulse iReal[0]=1000, all other samples 0, N=1024 → after L_core+1 cycles, every output bin is (1000, 0) per the core scaling, with oinv=0, osat=0, oerr=0.
- **Inverse, constant spectrum:** iinv=1, all bins (1024, 0), DIV_EXP=10 → oReal[0]=1024·1024/1024 per the core's scaling model and all other samples 0; oinv=1; matches the reference model bit-exactly, including rounding.
- **Interleaved frames:** four back-to-back frames with iinv = 0, 1, 1, 0 → output frames carry oinv = 0, 1, 1, 0 in order, each with correct data; oerr=0.
- **Mid-frame toggle:** iinv flips at iaddr=500 of an FFT frame → the entire frame is processed as FFT and oinv=0 on every beat of that frame.
- **Saturation:** IFFT frame whose core output imag is -131072 (W=18) → output imag is computed from 131071, and osat=1 on exactly that beat.
- **FIFO errors and reset:**
  - Force TAG_DEPTH_P+1 frame starts without any core output (stub core) → oerr=1.
  - Then assert rst_n=0 for 1 cycle mid-frame → all outputs are 0 on the next edge, oerr=0, and the next frame is processed correctly.
